// File: rtl/and_unit_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : and_unit_arbiter_if                                             |
// | Purpose  : Bundles the two requester handshakes, the result stage and the  |
// |            grant counters of and_unit_arbiter.                             |
// | Signals  : req0_vld/req0_a/req0_b/req0_rdy - requester 0 handshake         |
// |            req1_vld/req1_a/req1_b/req1_rdy - requester 1 handshake         |
// |            res_vld/res/res_id/res_rdy      - result stage handshake        |
// |            gnt_cnt0/gnt_cnt1               - saturating grant counters     |
// | Modports : slave  - the arbiter (consumes requests, produces results)      |
// |            master - the surrounding units / testbench                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface and_unit_arbiter_if;
  logic        req0_vld;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_rdy;
  logic        req1_vld;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_rdy;
  logic        res_vld;
  logic [15:0] res;
  logic        res_id;
  logic        res_rdy;
  logic [7:0]  gnt_cnt0;
  logic [7:0]  gnt_cnt1;

  modport slave (
    input  req0_vld, req0_a, req0_b,
    output req0_rdy,
    input  req1_vld, req1_a, req1_b,
    output req1_rdy,
    output res_vld, res, res_id,
    input  res_rdy,
    output gnt_cnt0, gnt_cnt1
  );

  modport master (
    output req0_vld, req0_a, req0_b,
    input  req0_rdy,
    output req1_vld, req1_a, req1_b,
    input  req1_rdy,
    input  res_vld, res, res_id,
    output res_rdy,
    input  gnt_cnt0, gnt_cnt1
  );
endinterface
`default_nettype wire

// File: rtl/and_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : and_unit_arbiter                                                |
// | Purpose  : Shares one 16-bit bitwise-AND datapath between two requesters.  |
// |            One request is granted per cycle; the result is registered with |
// |            the winner's ID into a single-entry output stage that is held   |
// |            until the consumer accepts it.                                  |
// | Ports    : clk   - sole clock, rising edge                                 |
// |            rst_n - synchronous active-low reset                            |
// |            bus   - and_unit_arbiter_if.slave (requests, result, counters)  |
// | Config   : AND_ARB_RR_EN defined   -> round-robin tie-break                |
// |            AND_ARB_RR_EN undefined -> requester 0 always wins ties         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module and_unit_arbiter (
  input  logic                  clk,
  input  logic                  rst_n,
  and_unit_arbiter_if.slave     bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        last_gnt;
  logic [15:0] res_q;
  logic        res_id_q;
  logic [7:0]  cnt0_q;
  logic [7:0]  cnt1_q;

  logic        free;
  logic        pick1;
  logic        win0;
  logic        win1;
  logic        take0;
  logic        take1;
  logic        take;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [15:0] and_res;

  // The slot can accept a new result when it is empty or is being drained
  // in this same cycle. Nothing is accepted while reset is asserted.
  assign free = rst_n && ((state == EMPTY) || bus.res_rdy);

  // Tie-break: which requester wins when both are valid.
`ifdef AND_ARB_RR_EN
  // The requester that did not win the last grant goes first.
  assign pick1 = ~last_gnt;
`else
  // Fixed priority to requester 0; last_gnt is still tracked but ignored.
  assign pick1 = last_gnt & 1'b0;
`endif

  assign win0  = bus.req0_vld && (!bus.req1_vld || !pick1);
  assign win1  = bus.req1_vld && (!bus.req0_vld ||  pick1);
  assign take0 = free && win0;
  assign take1 = free && win1;
  assign take  = take0 || take1;

  assign bus.req0_rdy = take0;
  assign bus.req1_rdy = take1;

  // Shared datapath: operand mux on the winner, then a lane-wise AND.
  assign sel_a   = take1 ? bus.req1_a : bus.req0_a;
  assign sel_b   = take1 ? bus.req1_b : bus.req0_b;
  assign and_res = {sel_a[15:8] & sel_b[15:8], sel_a[7:0] & sel_b[7:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (take) state_nxt = FULL;
      FULL: begin
        // Drain and refill in the same edge when a grant lines up with res_rdy.
        if (bus.res_rdy) state_nxt = take ? FULL : EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      res_q    <= 16'h0000;
      res_id_q <= 1'b0;
      last_gnt <= 1'b1;   // requester 0 wins the first tie
      cnt0_q   <= 8'h00;
      cnt1_q   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (take) begin
        res_q    <= and_res;
        res_id_q <= take1;
        last_gnt <= take1;
      end
      if (take0 && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'h01;
      if (take1 && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'h01;
    end
  end

  assign bus.res_vld  = (state == FULL);
  assign bus.res      = res_q;
  assign bus.res_id   = res_id_q;
  assign bus.gnt_cnt0 = cnt0_q;
  assign bus.gnt_cnt1 = cnt1_q;

endmodule
`default_nettype wire
